// File: rtl/pma_region_table.sv
// Runtime-programmable physical memory attribute table: NrRules base/length regions with
// attributes and sticky locks, a config read/write port and a one-register lookup pipeline.
module pma_region_table #(
  parameter int unsigned NrRules = 4,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRules*AddrWidth-1:0] RstBase = '0,
  parameter logic [NrRules*AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules*3-1:0] RstAttr = '0,
  parameter logic [NrRules-1:0] RstLock = '0,
  parameter logic [2:0] DefaultAttr = 3'b100,
  localparam int unsigned IW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [IW-1:0]        cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  input  logic                 cfg_re_i,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 req_ready_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IW-1:0]        rsp_idx_o,
  output logic [2:0]           rsp_attr_o
);

  localparam logic [IW:0] NrRulesW = (IW+1)'(NrRules);

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [2:0]           attr_q [NrRules];
  logic [NrRules-1:0]   lock_q;

  logic                 idx_ok;
  logic                 field_ok;
  logic                 wr_en;
  logic                 rd_ok;
  logic                 cfg_err_d;
  logic [AddrWidth-1:0] cfg_rdata_d;
  logic [AddrWidth-1:0] cfg_rdata_q;
  logic                 cfg_err_q;

  assign idx_ok   = {1'b0, cfg_idx_i} < NrRulesW;
  assign field_ok = cfg_field_i != 2'd3;
  // The lock bit is only consulted once the index is known to be in range.
  assign wr_en    = cfg_we_i && idx_ok && field_ok && !lock_q[cfg_idx_i];
  assign rd_ok    = idx_ok && field_ok;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
        len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        attr_q[i] <= RstAttr[i*3 +: 3];
      end
      lock_q <= RstLock;
    end else if (wr_en) begin
      case (cfg_field_i)
        2'd0: base_q[cfg_idx_i] <= cfg_wdata_i;
        2'd1: len_q[cfg_idx_i]  <= cfg_wdata_i;
        2'd2: begin
          attr_q[cfg_idx_i] <= cfg_wdata_i[2:0];
          lock_q[cfg_idx_i] <= cfg_wdata_i[3];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_rdata_d = '0;
    if (rd_ok) begin
      case (cfg_field_i)
        2'd0:    cfg_rdata_d = base_q[cfg_idx_i];
        2'd1:    cfg_rdata_d = len_q[cfg_idx_i];
        2'd2:    cfg_rdata_d = {{(AddrWidth-4){1'b0}}, lock_q[cfg_idx_i], attr_q[cfg_idx_i]};
        default: cfg_rdata_d = '0;
      endcase
    end
    cfg_err_d = (cfg_we_i && !wr_en) || (cfg_re_i && !rd_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_rdata_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (cfg_re_i) cfg_rdata_q <= cfg_rdata_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_rdata_o = cfg_rdata_q;
  assign cfg_err_o   = cfg_err_q;

  // Region end is formed one bit wider so a region reaching the top of memory never wraps.
  logic [NrRules-1:0] match;
  for (genvar gi = 0; gi < NrRules; gi++) begin : g_match
    logic [AddrWidth:0] end_w;
    assign end_w     = {1'b0, base_q[gi]} + {1'b0, len_q[gi]};
    assign match[gi] = (len_q[gi] != '0) && (req_addr_i >= base_q[gi])
                       && ({1'b0, req_addr_i} < end_w);
  end

  logic          hit_d;
  logic [IW-1:0] idx_d;
  logic [2:0]    attr_d;

  always_comb begin
    hit_d  = 1'b0;
    idx_d  = '0;
    attr_d = DefaultAttr;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_d  = 1'b1;
        idx_d  = IW'(i);
        attr_d = attr_q[i];
      end
    end
  end

  logic          rsp_valid_q;
  logic          rsp_hit_q;
  logic [IW-1:0] rsp_idx_q;
  logic [2:0]    rsp_attr_q;
  logic          accept;

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_attr_q  <= DefaultAttr;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_hit_q   <= hit_d;
      rsp_idx_q   <= idx_d;
      rsp_attr_q  <= attr_d;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_attr_o  = rsp_attr_q;

endmodule

// File: tb/tb_pma_region_table.sv
// Scoreboard bench for pma_region_table: directed lookups are queued with expected results
// and a negedge monitor checks every accepted response; config accesses are checked inline.
module tb_pma_region_table;

  localparam int NR = 3;
  localparam int AW = 64;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [1:0]    cfg_field = '0;
  logic [AW-1:0] cfg_wdata = '0;
  logic          cfg_re = 1'b0;
  logic [AW-1:0] cfg_rdata;
  logic          cfg_err;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_hit;
  logic [IW-1:0] rsp_idx;
  logic [2:0]    rsp_attr;

  always #5 clk = ~clk;

  pma_region_table #(
    .NrRules    (NR),
    .AddrWidth  (AW),
    .RstBase    ({64'h0, 64'h1_0000, 64'h8000_0000}),
    .RstLength  ({64'h1000, 64'h1_0000, 64'h4000_0000}),
    .RstAttr    ({3'b110, 3'b010, 3'b011}),
    .RstLock    (3'b000),
    .DefaultAttr(3'b100)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_we_i   (cfg_we),
    .cfg_idx_i  (cfg_idx),
    .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata),
    .cfg_re_i   (cfg_re),
    .cfg_rdata_o(cfg_rdata),
    .cfg_err_o  (cfg_err),
    .req_valid_i(req_valid),
    .req_addr_i (req_addr),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_hit_o  (rsp_hit),
    .rsp_idx_o  (rsp_idx),
    .rsp_attr_o (rsp_attr)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          hit;
    logic [IW-1:0] idx;
    logic [2:0]    attr;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a response presented with ready high completes at the next edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got hit=%0b idx=%0d attr=%03b, required no response",
                 rsp_hit, rsp_idx, rsp_attr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        if (rsp_hit !== e.hit || rsp_idx !== e.idx || rsp_attr !== e.attr) begin
          errors++;
          $display("FAIL rsp_%h: got hit=%0b idx=%0d attr=%03b, required hit=%0b idx=%0d attr=%03b",
                   e.addr, rsp_hit, rsp_idx, rsp_attr, e.hit, e.idx, e.attr);
        end else begin
          $display("rsp addr=%h hit=%0b idx=%0d attr=%03b ok", e.addr, rsp_hit, rsp_idx, rsp_attr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic lookup(input logic [AW-1:0] addr, input logic hit, input logic [IW-1:0] idx,
                        input logic [2:0] attr, input bit push);
    bit acc = 0;
    exp_t e;
    e.addr = addr; e.hit = hit; e.idx = idx; e.attr = attr;
    if (push) exp_q.push_back(e);
    req_valid = 1'b1;
    req_addr  = addr;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        acc = 1;
        break;
      end
    end
    req_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL req_timeout_%h: got no accept, required accept within 50 cycles", addr);
    end
  endtask

  task automatic cfg_write(input logic [IW-1:0] idx, input logic [1:0] field,
                           input logic [AW-1:0] data, input logic exp_err);
    cfg_we = 1'b1; cfg_idx = idx; cfg_field = field; cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    $display("cfg write idx=%0d field=%0d data=%h err=%0b", idx, field, data, cfg_err);
    check("wr_err", {63'd0, cfg_err}, {63'd0, exp_err});
  endtask

  task automatic cfg_read(input logic [IW-1:0] idx, input logic [1:0] field,
                          input logic [AW-1:0] exp_data, input logic exp_err);
    cfg_re = 1'b1; cfg_idx = idx; cfg_field = field;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    $display("cfg read idx=%0d field=%0d data=%h err=%0b", idx, field, cfg_rdata, cfg_err);
    check("rd_data", cfg_rdata, exp_data);
    check("rd_err", {63'd0, cfg_err}, {63'd0, exp_err});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_low", {63'd0, rsp_valid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hit", {63'd0, rsp_hit}, 64'd0);
    check("rst_idx", {62'd0, rsp_idx}, 64'd0);
    check("rst_attr", {61'd0, rsp_attr}, 64'd4);
    check("rst_rdata", cfg_rdata, 64'd0);
    check("rst_err", {63'd0, cfg_err}, 64'd0);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // Reset table and region boundaries
    lookup(64'h8000_1000, 1, 0, 3'b011, 1);
    lookup(64'h2000_0000, 0, 0, 3'b100, 1);
    lookup(64'hBFFF_FFFF, 1, 0, 3'b011, 1);
    lookup(64'hC000_0000, 0, 0, 3'b100, 1);

    // Write in the same cycle as a lookup: old attr now, new attr next
    cfg_we = 1'b1; cfg_idx = 0; cfg_field = 2; cfg_wdata = 64'h0;
    exp_q.push_back('{64'h8000_0000, 1'b1, 2'd0, 3'b011});
    req_valid = 1'b1; req_addr = 64'h8000_0000;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("simul_wr_err", {63'd0, cfg_err}, 64'd0);
    exp_q.push_back('{64'h8000_0000, 1'b1, 2'd0, 3'b000});
    @(posedge clk); #1;
    req_valid = 1'b0;

    // Region ending at the top of the address space
    cfg_write(1, 0, 64'hFFFF_FFFF_FFFF_F000, 0);
    cfg_write(1, 1, 64'h1000, 0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 3'b010, 1);
    lookup(64'hFFFF_FFFF_FFFF_EFFF, 0, 0, 3'b100, 1);
    lookup(64'h0, 1, 2, 3'b110, 1);

    // Overlap: lowest index wins until disabled by length 0
    cfg_write(0, 0, 64'h0, 0);
    cfg_write(0, 1, 64'h2000, 0);
    lookup(64'h0, 1, 0, 3'b000, 1);
    cfg_write(0, 1, 64'h0, 0);
    lookup(64'h0, 1, 2, 3'b110, 1);

    // Lock and error cases
    cfg_write(1, 2, 64'h9, 0);
    cfg_read(1, 2, 64'h9, 0);
    @(posedge clk); #1;
    check("rdata_hold", cfg_rdata, 64'h9);
    check("err_one_cycle", {63'd0, cfg_err}, 64'd0);
    cfg_write(1, 0, 64'h1234, 1);
    cfg_read(1, 0, 64'hFFFF_FFFF_FFFF_F000, 0);
    cfg_write(1, 2, 64'h1, 1);
    cfg_read(1, 2, 64'h9, 0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 3'b001, 1);
    cfg_write(0, 3, 64'h5, 1);
    cfg_write(3, 0, 64'h5, 1);
    cfg_read(3, 0, 64'h0, 1);
    cfg_read(0, 3, 64'h0, 1);

    // Read returns the pre-write value when both hit the same field
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_idx = 2; cfg_field = 0; cfg_wdata = 64'h5000;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_re = 1'b0;
    check("rw_same_old", cfg_rdata, 64'h0);
    cfg_read(2, 0, 64'h5000, 0);

    // Pending response is dropped by reset; table reloads and lock clears
    rsp_ready = 1'b0;
    lookup(64'h0, 1, 2, 3'b110, 0);
    do_reset();
    rsp_ready = 1'b1;
    cfg_read(1, 2, 64'h2, 0);
    cfg_read(1, 0, 64'h1_0000, 0);
    cfg_read(2, 0, 64'h0, 0);

    // Backpressure: one held response, two stalled requests, then drain
    rsp_ready = 1'b0;
    pop_cyc.delete();
    fork
      begin
        lookup(64'h8000_1000, 1, 0, 3'b011, 1);
        lookup(64'h1_0004, 1, 1, 3'b010, 1);
        lookup(64'h0, 1, 2, 3'b110, 1);
      end
      begin
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_ready_low", {63'd0, req_ready}, 64'd0);
          check("bp_hold", {58'd0, rsp_valid, rsp_hit, rsp_idx, rsp_attr},
                {58'd0, 1'b1, 1'b1, 2'd0, 3'b011});
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("bp_rsp_count", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      check("bp_consecutive_1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      check("bp_consecutive_2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
